echo_delay_ctrl: RTL
====================

Name: echo_delay_ctrl

Overview:
Sequencer for a stereo echo delay line held in one shared single-port sample RAM (one read or one write per cycle). On each sample strobe it schedules the left and right channels' read-old/write-new accesses in turn and presents the delayed sample pair to the echo mixers. The delay length is runtime-configurable. Sits between the codec sample interface and the echo mix/saturate stage.

Parameters:
ADDR_W, 12, per-channel pointer width; per-channel depth DEPTH = 2^ADDR_W samples
DATA_W, 24, sample width (two's complement)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
valid  in  1  one-cycle sample strobe; audio_in_l/r are valid in the same cycle
audio_in_l  in  DATA_W  left input sample
audio_in_r  in  DATA_W  right input sample
delay_len  in  ADDR_W  requested delay in samples
ram_addr  out  ADDR_W+1  RAM address {channel, pointer}; channel 0=L, 1=R
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle registered latency
dly_l  out  DATA_W  delayed left sample
dly_r  out  DATA_W  delayed right sample
dly_valid  out  1  one-cycle pulse when dly_l/dly_r update
busy  out  1  high while a sequence is running
overrun  out  1  sticky; set when valid arrives while busy

Behaviour:
- Clock port is clock. Reset port is reset: synchronous, active-high. All state is sampled on the clock's rising edge.
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, dly_l=0, dly_r=0, dly_valid=0, busy=0, overrun=0. Reset also clears wr_ptr=0, fill=0 and FSM=IDLE. RAM contents are not cleared.
- A reset asserted mid-sequence aborts the sequence immediately. No further RAM write occurs after the reset cycle.
- FSM states: IDLE, RD_L, WAIT_L, WR_L, RD_R, WAIT_R, WR_R, DONE.
- IDLE:
  - On valid, register audio_in_l/r and latch the effective delay: d = (delay_len==0) ? 1 : delay_len.
  - Compute rd_ptr = (wr_ptr - d) mod DEPTH, then go to RD_L.
- RD_L: ram_addr={0,rd_ptr}, ram_we=0.
- WAIT_L: ram_we=0. This state covers the RAM read latency.
- WR_L: capture ram_rdata into hold_l, then drive ram_addr={0,wr_ptr}, ram_we=1, ram_wdata=latched left sample.
- RD_R, WAIT_R, WR_R: same as the three left states with channel bit 1, capturing into hold_r.
- DONE:
  - dly_l = (fill >= d) ? hold_l : 0; dly_r likewise from hold_r.
  - dly_valid=1 for this cycle only.
  - wr_ptr increments with wrap at DEPTH; fill increments and saturates at DEPTH.
  - Return to IDLE.
- busy=1 in every state except IDLE.
- ram_we is high only in WR_L and WR_R. ram_addr and ram_wdata hold their last value when idle.
- Latency: valid sampled at edge N gives dly_valid high in the cycle after edge N+7. The sequence is 7 states long, so valid spacing must be at least 8 cycles; a valid arriving in DONE is ignored.
- A valid arriving while busy is dropped: no state change and no RAM access. overrun is set and stays set until reset.
- delay_len changes take effect only at the next accepted valid. d never changes mid-sequence.
- Delay semantics: an output at sample index k equals the input at index k-d once fill>=d, and is zero before that (priming).
- A read never hits the slot being written in the same sequence, because d>=1.
- Pointer wrap: wr_ptr goes from DEPTH-1 to 0. The rd_ptr subtraction is modulo 2^ADDR_W with no sign handling.

Test Plan:
- ADDR_W=4: reset, delay_len=3, feed L=k, R=-k for k=1..10 at 10-cycle spacing -> dly_l=0,0,0,1,2,...,7; dly_r=0,0,0,-1,...,-7; each dly_valid exactly 7 cycles after its valid.
- delay_len=0 -> behaves as delay 1: second output pair equals first input pair.
- delay_len=15, 40 samples -> wr_ptr wraps; output k equals input k-15 across the wrap; RAM address sequence checked per sample as L read, L write, R read, R write.
- valid asserted 4 cycles after a previous valid -> second sample dropped, overrun=1, no extra ram_we pulses; next valid at spacing 10 is processed normally.
- Change delay_len from 3 to 5 between samples -> the very next output uses d=5; the in-flight sequence is unaffected.
- Assert reset in WAIT_R -> next cycle busy=0, ram_we=0, dly_l/r=0, fill=0; subsequent outputs are primed zeros again.

Source files
------------

// File: rtl/echo_delay_ctrl.sv
// Stereo echo delay sequencer: time-shares one single-port sample RAM between the
// left and right delay lines, one read-old/write-new pair per channel per sample.
module echo_delay_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] audio_in_l,
    input  logic [DATA_W-1:0] audio_in_r,
    input  logic [ADDR_W-1:0] delay_len,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] dly_l,
    output logic [DATA_W-1:0] dly_r,
    output logic              dly_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FillMax = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StRdL, StWaitL, StWrL, StRdR, StWaitR, StWrR, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W:0]     fill_q;
    logic [ADDR_W-1:0]   d_q, d_d;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]   samp_l_q, samp_r_q;
    logic [DATA_W-1:0]   hold_l_q, hold_r_q;
    logic                accept;
    logic [ADDR_W:0]     addr_d;
    logic                we_d;
    logic [DATA_W-1:0]   wdata_d;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    accept  = 1'b1;
                    d_d     = (delay_len == '0) ? ADDR_W'(1) : delay_len;
                    state_d = StRdL;
                end
            end
            StRdL:   state_d = StWaitL;
            StWaitL: state_d = StWrL;
            StWrL:   state_d = StRdR;
            StRdR:   state_d = StWaitR;
            StWaitR: state_d = StWrR;
            StWrR:   state_d = StDone;
            StDone:  state_d = StIdle;
        endcase
    end

    // wr_ptr is stable for the whole sequence, so rd_ptr can be derived combinationally.
    assign rd_ptr = wr_ptr_q - d_d;

    // RAM strobes are registered against the state being entered so they line up with it.
    always_comb begin
        addr_d  = ram_addr;
        we_d    = 1'b0;
        wdata_d = ram_wdata;
        case (state_d)
            StRdL: addr_d = {1'b0, rd_ptr};
            StRdR: addr_d = {1'b1, rd_ptr};
            StWrL: begin
                addr_d  = {1'b0, wr_ptr_q};
                we_d    = 1'b1;
                wdata_d = samp_l_q;
            end
            StWrR: begin
                addr_d  = {1'b1, wr_ptr_q};
                we_d    = 1'b1;
                wdata_d = samp_r_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            d_q       <= ADDR_W'(1);
            samp_l_q  <= '0;
            samp_r_q  <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            dly_l     <= '0;
            dly_r     <= '0;
            dly_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            ram_addr  <= addr_d;
            ram_we    <= we_d;
            ram_wdata <= wdata_d;
            dly_valid <= (state_q == StDone);
            if (accept) begin
                samp_l_q <= audio_in_l;
                samp_r_q <= audio_in_r;
            end
            if (valid && state_q != StIdle) begin
                overrun <= 1'b1;
            end
            if (state_q == StWrL) begin
                hold_l_q <= ram_rdata;
            end
            if (state_q == StWrR) begin
                hold_r_q <= ram_rdata;
            end
            if (state_q == StDone) begin
                // Until d samples have been written the read slot holds stale data.
                dly_l    <= (fill_q >= {1'b0, d_q}) ? hold_l_q : '0;
                dly_r    <= (fill_q >= {1'b0, d_q}) ? hold_r_q : '0;
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (fill_q != FillMax) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule
